// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and helpers for the dmem_ctrl data memory.
// The BEAT1 state exists only when DMEM_MISALIGN_EN is defined.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [31:0] DEFAULT_MEM_BASE = 32'h0100_0000;

`ifdef DMEM_MISALIGN_EN
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, BEAT0, RESP} state_t;
`endif

  // Illegal size maps to 4 so the range check still sees a sane width.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_nbytes = 3'd1;
      SIZE_HALF: size_nbytes = 3'd2;
      default:   size_nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// One byte lane of the data memory: synchronous RAM, write enable, registered read.
// The read register only updates on an enabled read, so it holds between beats.
module dmem_lane #(
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_reg;

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked byte-addressable data memory with signed/unsigned load extension.
// DMEM_MISALIGN_EN enables two-beat servicing of accesses that span two lines.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = DEFAULT_MEM_BASE,
  parameter int          MEM_DEPTH = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int LINES = MEM_DEPTH / 4;
  localparam int LW    = $clog2(LINES);

  state_t          state_reg;
  logic            ready_reg, rsp_valid_reg, rsp_error_reg, load_ok_reg;
  logic [LW-1:0]   line_reg;
  logic [1:0]      off_reg;
  logic [2:0]      nbytes_reg;
  logic            signed_reg, write_reg;
  logic [31:0]     wdata_reg;
  logic [7:0]      lane_rdata [4];
  logic [7:0]      raw_byte [4];
  logic [31:0]     ext_data;

  logic [2:0]  req_nbytes;
  logic [32:0] req_last, mem_end;
  logic        req_err;

  assign req_nbytes = size_nbytes(req_size);
  assign req_last   = {1'b0, req_addr} + 33'(req_nbytes) - 33'd1;
  assign mem_end    = {1'b0, MEM_BASE} + 33'(MEM_DEPTH);

`ifdef DMEM_MISALIGN_EN
  logic span_reg;
  assign req_err = (req_size == 2'b11) || (req_addr < MEM_BASE) || (req_last >= mem_end);
`else
  logic [1:0] align_mask;
  assign align_mask = req_nbytes[1:0] - 2'd1;
  assign req_err = (req_size == 2'b11) || (req_addr < MEM_BASE) || (req_last >= mem_end)
                || ((req_addr[1:0] & align_mask) != 2'b00);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      ready_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_error_reg <= 1'b0;
      load_ok_reg   <= 1'b0;
      line_reg      <= '0;
      off_reg       <= 2'd0;
      nbytes_reg    <= 3'd1;
      signed_reg    <= 1'b0;
      write_reg     <= 1'b0;
      wdata_reg     <= 32'd0;
`ifdef DMEM_MISALIGN_EN
      span_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            ready_reg  <= 1'b0;
            line_reg   <= LW'((req_addr - MEM_BASE) >> 2);
            off_reg    <= req_addr[1:0];
            nbytes_reg <= req_nbytes;
            signed_reg <= req_signed;
            write_reg  <= req_write;
            wdata_reg  <= req_wdata;
`ifdef DMEM_MISALIGN_EN
            span_reg   <= ({1'b0, req_addr[1:0]} + req_nbytes) > 3'd4;
`endif
            if (req_err) begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_error_reg <= 1'b1;
            end else begin
              state_reg <= BEAT0;
            end
          end
        end
        BEAT0: begin
`ifdef DMEM_MISALIGN_EN
          if (span_reg) begin
            state_reg <= BEAT1;
          end else begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
            load_ok_reg   <= !write_reg;
          end
        end
        BEAT1: begin
`endif
          state_reg     <= RESP;
          rsp_valid_reg <= 1'b1;
          load_ok_reg   <= !write_reg;
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_error_reg <= 1'b0;
            load_ok_reg   <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Lanes at or above the offset hold the low bytes (line L); lanes below it wrap to line L+1.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [1:0]    rel, src;
      logic          active, en;
      logic [LW-1:0] lane_addr;

      assign rel    = 2'(gi) - off_reg;
      assign src    = 2'(gi) + off_reg;
      assign active = {1'b0, rel} < nbytes_reg;
`ifdef DMEM_MISALIGN_EN
      logic high;
      assign high      = {1'b0, off_reg} <= 3'(gi);
      assign en        = active && ((state_reg == BEAT0 && high) || (state_reg == BEAT1 && !high));
      assign lane_addr = high ? line_reg : line_reg + LW'(1);
`else
      assign en        = active && (state_reg == BEAT0);
      assign lane_addr = line_reg;
`endif
      assign raw_byte[gi] = lane_rdata[src];

      dmem_lane #(.DEPTH(LINES)) u_lane (
        .clock (clock),
        .en    (en),
        .we    (write_reg),
        .addr  (lane_addr),
        .wdata (wdata_reg[{rel, 3'b000} +: 8]),
        .rdata (lane_rdata[gi])
      );
    end
  endgenerate

  always_comb begin
    ext_data = {raw_byte[3], raw_byte[2], raw_byte[1], raw_byte[0]};
    if (nbytes_reg == 3'd1)
      ext_data = {{24{signed_reg & raw_byte[0][7]}}, raw_byte[0]};
    else if (nbytes_reg == 3'd2)
      ext_data = {{16{signed_reg & raw_byte[1][7]}}, raw_byte[1], raw_byte[0]};
  end

  assign req_ready = ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_error = rsp_error_reg;
  assign rsp_rdata = load_ok_reg ? ext_data : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: loads/stores, extension, range errors, back-pressure, reset.
// Misaligned expectations follow DMEM_MISALIGN_EN.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [1:0]  req_size = SIZE_WORD;
  logic        req_ready, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request from #1 after an edge; latency counts edges from the accepting edge.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] wd,
                     input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_addr = a; req_wdata = wd; req_write = w; req_size = sz; req_signed = sg;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    $display("xact %-10s addr=%h we=%0d size=%0d sg=%0d -> rdata=%h err=%0d lat=%0d",
             tag, a, w, sz, sg, rsp_rdata, rsp_error, lat);
    check({tag, ".lat"},   32'(lat),       32'(exp_lat));
    check({tag, ".rdata"}, rsp_rdata,      exp_rd);
    check({tag, ".err"},   32'(rsp_error), 32'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clock);
    #1;
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.error", 32'(rsp_error), 32'd0);
    check("rst.rdata", rsp_rdata,      32'd0);
    check("rst.ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    check("rel.ready", 32'(req_ready), 32'd1);

    run("st_w",    32'h0100_0010, 32'hDEADBEEF, 1, SIZE_WORD, 0, 32'h0,        0, 2);
    run("ld_w",    32'h0100_0010, 32'h0,        0, SIZE_WORD, 0, 32'hDEADBEEF, 0, 2);
    run("ld_bs",   32'h0100_0013, 32'h0,        0, SIZE_BYTE, 1, 32'hFFFFFFDE, 0, 2);
    run("ld_bu",   32'h0100_0013, 32'h0,        0, SIZE_BYTE, 0, 32'h000000DE, 0, 2);
    run("ld_hs",   32'h0100_0012, 32'h0,        0, SIZE_HALF, 1, 32'hFFFFDEAD, 0, 2);
    run("ld_hu",   32'h0100_0010, 32'h0,        0, SIZE_HALF, 0, 32'h0000BEEF, 0, 2);
    run("ld_b0",   32'h0100_0010, 32'h0,        0, SIZE_BYTE, 1, 32'hFFFFFFEF, 0, 2);
    run("st_b",    32'h0100_0011, 32'hFFFF_FF55, 1, SIZE_BYTE, 0, 32'h0,       0, 2);
    run("ld_w2",   32'h0100_0010, 32'h0,        0, SIZE_WORD, 1, 32'hDEAD55EF, 0, 2);
    run("st_h",    32'h0100_0016, 32'hAAAA_1234, 1, SIZE_HALF, 0, 32'h0,       0, 2);
    run("ld_h2",   32'h0100_0016, 32'h0,        0, SIZE_HALF, 1, 32'h00001234, 0, 2);
    run("err_lo",  32'h00FF_FFFC, 32'h0,        0, SIZE_WORD, 0, 32'h0,        1, 1);
    run("err_hi",  32'h010F_FFFE, 32'h0,        0, SIZE_WORD, 0, 32'h0,        1, 1);
    run("err_end", 32'h0110_0000, 32'h0,        0, SIZE_BYTE, 0, 32'h0,        1, 1);
    run("err_wrap",32'hFFFF_FFFC, 32'h0,        0, SIZE_WORD, 0, 32'h0,        1, 1);
    run("err_sz",  32'h0100_0010, 32'h0,        0, 2'b11,     0, 32'h0,        1, 1);
    run("st_last", 32'h010F_FFFF, 32'h0000_0080, 1, SIZE_BYTE, 0, 32'h0,       0, 2);
    run("ld_last", 32'h010F_FFFF, 32'h0,        0, SIZE_BYTE, 1, 32'hFFFFFF80, 0, 2);

    run("st_w20",  32'h0100_0020, 32'hCAFEF00D, 1, SIZE_WORD, 0, 32'h0,        0, 2);
    run("st_w24",  32'h0100_0024, 32'h0,        1, SIZE_WORD, 0, 32'h0,        0, 2);
`ifdef DMEM_MISALIGN_EN
    run("st_mis",  32'h0100_0022, 32'h11223344, 1, SIZE_WORD, 0, 32'h0,        0, 3);
    run("ld_mis",  32'h0100_0022, 32'h0,        0, SIZE_WORD, 0, 32'h11223344, 0, 3);
    run("ld_w20",  32'h0100_0020, 32'h0,        0, SIZE_WORD, 0, 32'h3344F00D, 0, 2);
    run("ld_hmis", 32'h0100_0023, 32'h0,        0, SIZE_HALF, 1, 32'h00002233, 0, 3);
`else
    run("st_mis",  32'h0100_0022, 32'h11223344, 1, SIZE_WORD, 0, 32'h0,        1, 1);
    run("ld_w20",  32'h0100_0020, 32'h0,        0, SIZE_WORD, 0, 32'hCAFEF00D, 0, 2);
    run("ld_hmis", 32'h0100_0021, 32'h0,        0, SIZE_HALF, 0, 32'h0,        1, 1);
`endif

    // Back-pressure: response must hold while rsp_ready is low.
    req_addr = 32'h0100_0010; req_write = 1'b0; req_size = SIZE_WORD; req_signed = 1'b0;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check("bp.lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", 32'(rsp_valid), 32'd1);
      check("bp.rdata", rsp_rdata,      32'hDEAD55EF);
      check("bp.error", 32'(rsp_error), 32'd0);
      check("bp.ready", 32'(req_ready), 32'd0);
      @(posedge clock); #1;
    end
    $display("xact bp         addr=%h held 5 cycles rdata=%h", req_addr, rsp_rdata);
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    check("bp.rel_ready", 32'(req_ready), 32'd1);
    check("bp.rel_valid", 32'(rsp_valid), 32'd0);

    // Reset during BEAT0 of a store: the beat is dropped and memory keeps its data.
    req_addr = 32'h0100_0010; req_wdata = 32'h0; req_write = 1'b1; req_size = SIZE_WORD;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    $display("xact rst_beat0  addr=%h reset mid-access valid=%0d ready=%0d",
             req_addr, rsp_valid, req_ready);
    check("rb.valid", 32'(rsp_valid), 32'd0);
    check("rb.ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    run("ld_after", 32'h0100_0010, 32'h0, 0, SIZE_WORD, 0, 32'hDEAD55EF, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
